result_display: RTL and testbench

Downstream consumer of the SoC's 16-bit `result` bus. It converts the unsigned binary value to five BCD digits with a sequential double-dabble engine, then drives a multiplexed, active-low 7-segment display on the board. It re-converts automatically whenever `result` changes, and it is the only display path for SoC computation output.

---
 rtl/result_display_pkg.sv | 48 ++++
 rtl/result_display_if.sv | 22 ++
 rtl/bin2bcd_seq.sv | 74 +++++++
 rtl/result_display.sv | 98 +++++++++
 tb/tb_result_display.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/result_display_pkg.sv
// rtl/result_display_pkg.sv - shared types, widths and 7-segment constants for result_display
package result_display_pkg;

  // Converter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_e;

  localparam int NUM_DIGITS = 5;
  localparam int BCD_W      = 20;
  localparam int BIN_W      = 16;
  localparam int DIV_W      = 24;

  // Active-low segment patterns, bit 0 = a ... bit 6 = g, bit 7 = dp (off)
  localparam logic [7:0] SEG_0   = 8'hC0;
  localparam logic [7:0] SEG_1   = 8'hF9;
  localparam logic [7:0] SEG_2   = 8'hA4;
  localparam logic [7:0] SEG_3   = 8'hB0;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h92;
  localparam logic [7:0] SEG_6   = 8'h82;
  localparam logic [7:0] SEG_7   = 8'hF8;
  localparam logic [7:0] SEG_8   = 8'h80;
  localparam logic [7:0] SEG_9   = 8'h90;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // BCD digit to active-low segments; non-decimal nibbles go dark
  function automatic logic [7:0] seg_decode(input logic [3:0] digit);
    logic [7:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_OFF;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/result_display_if.sv
// rtl/result_display_if.sv - binary value in, BCD result and busy out, between display and converter
interface result_display_if;
  import result_display_pkg::*;

  logic [BIN_W-1:0] result;
  logic [BCD_W-1:0] bcd;
  logic             busy;

  // Side that supplies the value and consumes the conversion
  modport master (
    output result,
    input  bcd,
    input  busy
  );

  // Converter side
  modport slave (
    input  result,
    output bcd,
    output busy
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter, re-runs whenever result differs from the last value taken
module bin2bcd_seq
  import result_display_pkg::*;
(
  input  logic             base_clk,
  input  logic             reset,
  result_display_if.slave  conv
);

  conv_state_e      r_state;
  logic [BIN_W-1:0] r_last;
  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_acc;
  logic [3:0]       r_cnt;
  logic [BCD_W-1:0] r_bcd;
  logic             r_busy;
  logic [BCD_W-1:0] w_adj;

  // Add-3 correction on every nibble that would overflow past 9 after the shift
  always_comb begin
    w_adj = r_acc;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_acc[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
      end
    end
  end

  // Converter FSM: sample on change, 16 shift iterations, then publish bcd in one cycle
  always_ff @(posedge base_clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_last  <= '0;
      r_bin   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (conv.result != r_last) begin
            r_last  <= conv.result;
            r_bin   <= conv.result;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CONV;
          end
        end
        CONV: begin
          {r_acc, r_bin} <= {w_adj, r_bin} << 1;
          r_cnt          <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_bcd   <= r_acc;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign conv.bcd  = r_bcd;
  assign conv.busy = r_busy;

endmodule

// File: rtl/result_display.sv
// rtl/result_display.sv - 16-bit result to 5-digit multiplexed 7-segment display; RESULT_DISPLAY_BLANK_EN enables leading-zero blanking
module result_display
  import result_display_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic             base_clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] result,
  output logic [7:0]       seg,
  output logic [7:0]       an,
  output logic [BCD_W-1:0] bcd,
  output logic             busy
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

  result_display_if u_conv_if ();

  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_idx;
  logic [7:0]       r_seg;
  logic [7:0]       r_an;
  logic [3:0]       w_nibble;
  logic             w_blank;
  logic [7:0]       w_seg;

  assign u_conv_if.result = result;

  bin2bcd_seq u_bin2bcd (
    .base_clk (base_clk),
    .reset    (reset),
    .conv     (u_conv_if)
  );

  assign bcd  = u_conv_if.bcd;
  assign busy = u_conv_if.busy;

  // Select the nibble for the digit currently being scanned
  always_comb begin
    w_nibble = 4'd0;
    case (r_idx)
      3'd0:    w_nibble = bcd[3:0];
      3'd1:    w_nibble = bcd[7:4];
      3'd2:    w_nibble = bcd[11:8];
      3'd3:    w_nibble = bcd[15:12];
      3'd4:    w_nibble = bcd[19:16];
      default: w_nibble = 4'd0;
    endcase
  end

`ifdef RESULT_DISPLAY_BLANK_EN
  // Blank digit k when it and every more significant digit are zero; digit 0 always shows
  always_comb begin
    w_blank = 1'b0;
    case (r_idx)
      3'd1:    w_blank = (bcd[19:4]  == 16'd0);
      3'd2:    w_blank = (bcd[19:8]  == 12'd0);
      3'd3:    w_blank = (bcd[19:12] == 8'd0);
      3'd4:    w_blank = (bcd[19:16] == 4'd0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  assign w_seg = w_blank ? SEG_OFF : seg_decode(w_nibble);

  // Prescaler and digit index: each digit holds for SCAN_DIV cycles, cycling 0..4
  always_ff @(posedge base_clk or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_idx <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Registered display drive, one stage behind index and bcd
  always_ff @(posedge base_clk or negedge reset) begin
    if (!reset) begin
      r_seg <= SEG_OFF;
      r_an  <= 8'hFF;
    end else begin
      r_seg <= w_seg;
      r_an  <= ~(8'd1 << r_idx);
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_result_display.sv
// tb/tb_result_display.sv - randomized self-checking bench for result_display against a decimal reference model
module tb_result_display;
  import result_display_pkg::*;

  localparam int SCAN_DIV = 4;

  logic       base_clk = 1'b0;
  logic       reset    = 1'b0;
  logic [7:0] seg;
  logic [7:0] an;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         edges    = 0;
  int         last_val = 0;

  result_display_if u_if ();

  result_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .base_clk (base_clk),
    .reset    (reset),
    .result   (u_if.result),
    .seg      (seg),
    .an       (an),
    .bcd      (u_if.bcd),
    .busy     (u_if.busy)
  );

  always #5 base_clk = ~base_clk;

  always @(posedge base_clk) begin
    if (!reset) edges = 0;
    else        edges = edges + 1;
  end

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [19:0] model_bcd(input int v);
    logic [19:0] r = '0;
    for (int k = 0; k < 5; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic logic [7:0] model_seg(input int v, input int idx);
    int digit;
    logic [7:0] lut [10];
    lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    digit = (v / pow10(idx)) % 10;
`ifdef RESULT_DISPLAY_BLANK_EN
    if (idx > 0 && (v / pow10(idx)) == 0) return 8'hFF;
`endif
    return lut[digit];
  endfunction

  function automatic int model_idx(input int n);
    return ((n - 1) / SCAN_DIV) % 5;
  endfunction

  task automatic tick();
    @(posedge base_clk);
    #1;
  endtask

  task automatic wait_busy_fall(output int cycles);
    cycles = 0;
    while (u_if.busy === 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
    n_checks++;
    if (u_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", u_if.busy, cycles);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    u_if.result = 16'd45;
    repeat (3) tick();
    n_checks += 4;
    if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h required FF", seg); end
    if (an !== 8'hFF) begin n_fail++; $display("FAIL reset_an: got %h required FF", an); end
    if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", u_if.busy); end
    if (u_if.bcd !== 20'h0) begin n_fail++; $display("FAIL reset_bcd: got %h required 00000", u_if.bcd); end
    reset = 1'b1;
    tick();
    n_checks += 3;
    if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL release_busy: got %b required 1", u_if.busy); end
    if (an !== 8'hFE) begin n_fail++; $display("FAIL release_an: got %h required FE", an); end
    if (seg !== 8'hC0) begin n_fail++; $display("FAIL release_seg: got %h required C0", seg); end
  endtask

  task automatic test_convert_45();
    repeat (16) tick();
    n_checks += 2;
    if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL c45_busy_e16: got %b required 1", u_if.busy); end
    if (u_if.bcd !== 20'h0) begin n_fail++; $display("FAIL c45_bcd_e16: got %h required 00000", u_if.bcd); end
    tick();
    n_checks += 2;
    if (u_if.bcd !== model_bcd(45)) begin n_fail++; $display("FAIL c45_bcd: got %h required %h", u_if.bcd, model_bcd(45)); end
    if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL c45_busy_e17: got %b required 0", u_if.busy); end
    last_val = 45;
  endtask

  task automatic test_scan();
    logic [7:0] exp_an;
    logic [7:0] exp_seg;
    int idx;
    for (int i = 0; i < 44; i++) begin
      tick();
      idx = model_idx(edges);
      exp_an = ~(8'd1 << idx);
      exp_seg = model_seg(last_val, idx);
      n_checks += 2;
      if (an !== exp_an) begin n_fail++; $display("FAIL scan_an edge %0d: got %h required %h", edges, an, exp_an); end
      if (seg !== exp_seg) begin n_fail++; $display("FAIL scan_seg edge %0d: got %h required %h", edges, seg, exp_seg); end
    end
  endtask

  task automatic test_max();
    int cycles;
    u_if.result = 16'hFFFF;
    tick();
    n_checks++;
    if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL max_busy_rise: got %b required 1", u_if.busy); end
    wait_busy_fall(cycles);
    n_checks += 2;
    if (cycles !== 17) begin n_fail++; $display("FAIL max_busy_len: got %0d required 17", cycles); end
    if (u_if.bcd !== 20'h65535) begin n_fail++; $display("FAIL max_bcd: got %h required 65535", u_if.bcd); end
    last_val = 65535;
  endtask

  task automatic test_back_to_back();
    int e0, t100, trise, t200;
    bit bad;
    logic prev_busy;
    e0 = 0; t100 = 0; trise = 0; t200 = 0; bad = 0;
    u_if.result = 16'd100;
    tick();
    e0 = edges;
    prev_busy = u_if.busy;
    repeat (5) tick();
    u_if.result = 16'd200;
    for (int i = 0; i < 60 && t200 == 0; i++) begin
      tick();
      if (u_if.bcd !== model_bcd(65535) && u_if.bcd !== model_bcd(100) && u_if.bcd !== model_bcd(200)) bad = 1;
      if (t100 == 0 && u_if.bcd === model_bcd(100)) t100 = edges;
      if (trise == 0 && prev_busy === 1'b0 && u_if.busy === 1'b1) trise = edges;
      if (u_if.bcd === model_bcd(200)) t200 = edges;
      prev_busy = u_if.busy;
    end
    n_checks += 5;
    if (bad) begin n_fail++; $display("FAIL b2b_intermediate: unexpected bcd value seen, last %h", u_if.bcd); end
    if (t100 !== e0 + 17) begin n_fail++; $display("FAIL b2b_first_done: edge %0d required %0d", t100, e0 + 17); end
    if (trise !== e0 + 18) begin n_fail++; $display("FAIL b2b_second_sample: edge %0d required %0d", trise, e0 + 18); end
    if (t200 !== e0 + 35) begin n_fail++; $display("FAIL b2b_second_done: edge %0d required %0d", t200, e0 + 35); end
    if (u_if.bcd !== model_bcd(200)) begin n_fail++; $display("FAIL b2b_final: got %h required %h", u_if.bcd, model_bcd(200)); end
    last_val = 200;
  endtask

  task automatic test_random();
    int vals [12];
    int v, cycles, idx;
    vals[0] = 0; vals[1] = 9; vals[2] = 10; vals[3] = 65534;
    for (int i = 4; i < 12; i++) vals[i] = int'($urandom_range(0, 65535));
    for (int i = 0; i < 12; i++) begin
      v = vals[i];
      if (v == last_val) v = v ^ 1;
      u_if.result = 16'(v);
      tick();
      n_checks++;
      if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL rand_busy_rise value %0d: got %b required 1", v, u_if.busy); end
      wait_busy_fall(cycles);
      n_checks++;
      if (u_if.bcd !== model_bcd(v)) begin n_fail++; $display("FAIL rand_bcd value %0d: got %h required %h", v, u_if.bcd, model_bcd(v)); end
      last_val = v;
      repeat (i % 5 + 1) tick();
      idx = model_idx(edges);
      n_checks++;
      if (seg !== model_seg(v, idx)) begin n_fail++; $display("FAIL rand_seg value %0d digit %0d: got %h required %h", v, idx, seg, model_seg(v, idx)); end
    end
  endtask

  task automatic test_reset_mid();
    int v, cycles;
    v = int'($urandom_range(1, 65535));
    if (v == last_val) v = (v == 1) ? 2 : v - 1;
    u_if.result = 16'(v);
    tick();
    repeat ($urandom_range(2, 10)) tick();
    #2;
    reset = 1'b0;
    #1;
    n_checks += 4;
    if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b required 0", u_if.busy); end
    if (u_if.bcd !== 20'h0) begin n_fail++; $display("FAIL rmid_bcd: got %h required 00000", u_if.bcd); end
    if (an !== 8'hFF) begin n_fail++; $display("FAIL rmid_an: got %h required FF", an); end
    if (seg !== 8'hFF) begin n_fail++; $display("FAIL rmid_seg: got %h required FF", seg); end
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL rmid_reconvert_start: got %b required 1", u_if.busy); end
    wait_busy_fall(cycles);
    n_checks++;
    if (u_if.bcd !== model_bcd(v)) begin n_fail++; $display("FAIL rmid_reconvert: got %h required %h", u_if.bcd, model_bcd(v)); end
    last_val = v;
  endtask

  initial begin
    u_if.result = 16'd0;
    test_reset();
    test_convert_45();
    test_scan();
    test_max();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
